// File: rtl/ppu_attr_uploader_if.sv
// Bus bundle for ppu_attr_uploader: host-side shadow write port and
// PPU-side register write port. The uploader uses the master view, the
// host bridge / PPU environment uses the slave view.
interface ppu_attr_uploader_if;
  logic        host_valid;
  logic        host_ready;
  logic [3:0]  host_index;
  logic [31:0] host_data;
  logic        ppu_chipselect;
  logic        ppu_write;
  logic [15:0] ppu_address;
  logic [31:0] ppu_writedata;

  modport master (
    input  host_valid, host_index, host_data,
    output host_ready, ppu_chipselect, ppu_write, ppu_address, ppu_writedata
  );

  modport slave (
    output host_valid, host_index, host_data,
    input  host_ready, ppu_chipselect, ppu_write, ppu_address, ppu_writedata
  );
endinterface

// File: rtl/ppu_attr_uploader.sv
// ppu_attr_uploader: CPU-side shadow of the PPU sprite attribute table.
// After a commit pulse, the shadow is replayed into the PPU as a burst of
// NUM_ATTR back-to-back register writes starting at the next vblank rise.
// Optional feature: define PPU_ATTR_UPLOADER_DIRTY_EN to write only the
// entries touched by the host since they were last uploaded.
module ppu_attr_uploader #(
  parameter int unsigned NUM_ATTR  = 16,
  parameter logic [1:0]  TABLE_SEL = 2'b00
) (
  input  logic                  clk,
  input  logic                  reset,
  ppu_attr_uploader_if.master   bus,
  input  logic                  commit,
  input  logic                  vblank,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned IW = (NUM_ATTR > 1) ? $clog2(NUM_ATTR) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_ATTR - 1);

  typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          vblank_q;
  logic          commit_pend_q, commit_pend_d;
  logic          cs_q, cs_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          done_q, done_d;
  logic [31:0]   shadow_q [NUM_ATTR];

  logic          vblank_edge;
  logic          host_wr;
  logic [IW-1:0] host_idx;
  logic          load;
  logic [IW-1:0] load_idx;

`ifdef PPU_ATTR_UPLOADER_DIRTY_EN
  logic [NUM_ATTR-1:0] dirty_q;
`endif

  assign vblank_edge = vblank & ~vblank_q;
  assign host_wr     = bus.host_valid & bus.host_ready;
  assign host_idx    = bus.host_index[IW-1:0];

  // Next-state and registered-output computation; every output of the
  // block is a flop loaded from here, so the first PPU write appears in
  // the same cycle the FSM enters COPY.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    commit_pend_d = commit_pend_q;
    cs_d          = 1'b0;
    addr_d        = '0;
    data_d        = '0;
    done_d        = 1'b0;
    load          = 1'b0;
    load_idx      = '0;

    case (state_q)
      IDLE: begin
        if (commit) state_d = PENDING;
      end
      PENDING: begin
        if (vblank_edge) begin
          state_d  = COPY;
          idx_d    = '0;
          load     = 1'b1;
          load_idx = '0;
        end
      end
      COPY: begin
        if (commit) commit_pend_d = 1'b1;
        if (idx_q == LAST) begin
          // A commit seen during the burst (or on its final cycle) re-arms
          // the uploader for the next vblank instead of being dropped.
          state_d       = (commit_pend_q | commit) ? PENDING : IDLE;
          commit_pend_d = 1'b0;
          done_d        = 1'b1;
        end else begin
          idx_d    = idx_q + IW'(1);
          load     = 1'b1;
          load_idx = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
`ifdef PPU_ATTR_UPLOADER_DIRTY_EN
      cs_d = dirty_q[load_idx];
`else
      cs_d = 1'b1;
`endif
      addr_d = {6'b0, TABLE_SEL, 4'b0, 4'(load_idx)};
      data_d = shadow_q[load_idx];
    end
  end

  // FSM state, copy index, edge detector and registered PPU outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      vblank_q      <= 1'b0;
      commit_pend_q <= 1'b0;
      cs_q          <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      vblank_q      <= vblank;
      commit_pend_q <= commit_pend_d;
      cs_q          <= cs_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      done_q        <= done_d;
    end
  end

  // Shadow table: host writes land here whenever the host port is open.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ATTR; i++) shadow_q[i] <= '0;
    end else if (host_wr) begin
      shadow_q[host_idx] <= bus.host_data;
    end
  end

`ifdef PPU_ATTR_UPLOADER_DIRTY_EN
  // Dirty tracking: cleared as an entry is scanned, set by a host write;
  // a write coinciding with the scan of its entry keeps it dirty so the
  // new value goes out with the next upload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirty_q <= '0;
    end else begin
      if (load)    dirty_q[load_idx] <= 1'b0;
      if (host_wr) dirty_q[host_idx] <= 1'b1;
    end
  end
`endif

  assign bus.host_ready     = ~reset & (state_q != COPY);
  assign bus.ppu_chipselect = cs_q;
  assign bus.ppu_write      = cs_q;
  assign bus.ppu_address    = addr_q;
  assign bus.ppu_writedata  = data_q;
  assign busy               = (state_q != IDLE);
  assign done               = done_q;

endmodule

// File: tb/tb_ppu_attr_uploader.sv
module tb_ppu_attr_uploader;

`ifdef PPU_ATTR_UPLOADER_DIRTY_EN
  localparam bit DIRTY = 1'b1;
`else
  localparam bit DIRTY = 1'b0;
`endif
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;
  localparam logic [31:0] ATTR = 32'hA0F0_2864;
  localparam logic [31:0] HELD = 32'h1234_5678;

  logic clk;
  logic reset;
  logic commit;
  logic vblank;
  logic busy;
  logic done;

  ppu_attr_uploader_if bus ();

  ppu_attr_uploader #(.NUM_ATTR(16), .TABLE_SEL(2'b00)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .commit (commit),
    .vblank (vblank),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] cap [16];

  typedef struct {
    logic        hv;
    logic [3:0]  hi;
    logic [31:0] hd;
    logic        cm;
    logic        vb;
    logic        rdy;
    logic        cs;
    logic [15:0] addr;
    logic [31:0] data;
    logic        bsy;
    logic        dn;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic hv, input logic [3:0] hi, input logic [31:0] hd,
                              input logic cm, input logic vb, input logic rdy, input logic cs,
                              input logic [15:0] addr, input logic [31:0] data,
                              input logic bsy, input logic dn);
    vec_t v;
    v.hv = hv; v.hi = hi; v.hd = hd; v.cm = cm; v.vb = vb;
    v.rdy = rdy; v.cs = cs; v.addr = addr; v.data = data; v.bsy = bsy; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  // Drop vblank for a cycle, raise it, then watch up to 40 cycles for the
  // burst; returns write count, sample index of done (0 if never seen),
  // cycles with host_ready low while busy, and busy at the done sample.
  task automatic burst(input int commit_at, input bit hold, output int writes,
                       output int cyc, output int rdy_low, output bit busy_done);
    writes = 0; cyc = 0; rdy_low = 0; busy_done = 1'b0;
    for (int i = 0; i < 16; i++) cap[i] = SENT;
    vblank = 1'b0;
    @(negedge clk);
    vblank = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (commit) commit = 1'b0;
      if (done) begin
        cyc = n;
        busy_done = busy;
        break;
      end
      if (bus.ppu_write) begin
        writes++;
        cap[bus.ppu_address[3:0]] = bus.ppu_writedata;
      end
      if (!bus.host_ready && busy) rdy_low++;
      if (n == commit_at) commit = 1'b1;
      if (hold && n == 1) begin
        bus.host_valid = 1'b1; bus.host_index = 4'd7; bus.host_data = HELD;
      end
    end
    if (hold) begin
      @(negedge clk);
      bus.host_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, c, rl;
    bit bd;

    vecs[0] = mk(1, 4'd3, ATTR, 0, 0, 1, 0, 16'h0000, 32'h0, 0, 0);
    vecs[1] = mk(0, 4'd0, 32'h0, 1, 0, 1, 0, 16'h0000, 32'h0, 1, 0);
    vecs[2] = mk(0, 4'd0, 32'h0, 0, 0, 1, 0, 16'h0000, 32'h0, 1, 0);
    for (int i = 0; i < 16; i++)
      vecs[3+i] = mk(0, 4'd0, 32'h0, 0, 1, 0, DIRTY ? (i == 3) : 1'b1,
                     16'(i), (i == 3) ? ATTR : 32'h0, 1, 0);
    vecs[19] = mk(0, 4'd0, 32'h0, 0, 1, 1, 0, 16'h0000, 32'h0, 0, 1);
    vecs[20] = mk(0, 4'd0, 32'h0, 0, 0, 1, 0, 16'h0000, 32'h0, 0, 0);

    reset = 1'b1; commit = 1'b0; vblank = 1'b0;
    bus.host_valid = 1'b0; bus.host_index = 4'd0; bus.host_data = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.host_ready, 0);
    chk("rst_cs", bus.ppu_chipselect, 0);
    chk("rst_write", bus.ppu_write, 0);
    chk("rst_addr", bus.ppu_address, 0);
    chk("rst_data", bus.ppu_writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // Basic upload: write shadow[3], commit, vblank rise, full burst.
    for (int v = 0; v < 21; v++) begin
      bus.host_valid = vecs[v].hv; bus.host_index = vecs[v].hi; bus.host_data = vecs[v].hd;
      commit = vecs[v].cm; vblank = vecs[v].vb;
      @(negedge clk);
      chk($sformatf("tbl_ready[%0d]", v), bus.host_ready, vecs[v].rdy);
      chk($sformatf("tbl_cs[%0d]", v), bus.ppu_chipselect, vecs[v].cs);
      chk($sformatf("tbl_write[%0d]", v), bus.ppu_write, vecs[v].cs);
      chk($sformatf("tbl_addr[%0d]", v), bus.ppu_address, vecs[v].addr);
      chk($sformatf("tbl_data[%0d]", v), bus.ppu_writedata, vecs[v].data);
      chk($sformatf("tbl_busy[%0d]", v), busy, vecs[v].bsy);
      chk($sformatf("tbl_done[%0d]", v), done, vecs[v].dn);
    end
    commit = 1'b0;

    // No commit: vblank toggling must never start a burst.
    burst(0, 0, w, c, rl, bd);
    chk("nocommit_writes", w, 0);
    chk("nocommit_done", c, 0);
    chk("nocommit_busy", busy, 0);

    // host_valid held across a burst: blocked for 16 cycles, lands after.
    pulse_commit();
    burst(0, 1, w, c, rl, bd);
    chk("hold_writes", w, DIRTY ? 0 : 16);
    chk("hold_done_cyc", c, 17);
    chk("hold_ready_low", rl, 16);
    chk("hold_busy_at_done", bd, 0);
    chk("hold_e3", cap[3], DIRTY ? SENT : ATTR);
    chk("hold_e7_old", cap[7], DIRTY ? SENT : 32'h0);

    // Next upload carries the held write; commit mid-burst re-arms it.
    pulse_commit();
    burst(5, 0, w, c, rl, bd);
    chk("mid_writes", w, DIRTY ? 1 : 16);
    chk("mid_e7_new", cap[7], HELD);
    chk("mid_done_cyc", c, 17);
    chk("mid_busy_at_done", bd, 1);
    burst(0, 0, w, c, rl, bd);
    chk("rearm_writes", w, DIRTY ? 0 : 16);
    chk("rearm_done_cyc", c, 17);
    chk("rearm_busy_at_done", bd, 0);
    chk("rearm_e7", cap[7], DIRTY ? SENT : HELD);

    // Reset while copying entry 7.
    pulse_commit();
    vblank = 1'b0;
    @(negedge clk);
    vblank = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_rst_idx", bus.ppu_address, 16'h0007);
    reset = 1'b1;
    #1;
    chk("mid_rst_cs", bus.ppu_chipselect, 0);
    chk("mid_rst_write", bus.ppu_write, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", bus.host_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    burst(0, 0, w, c, rl, bd);
    chk("post_rst_writes", w, 0);
    chk("post_rst_done", c, 0);
    pulse_commit();
    burst(0, 0, w, c, rl, bd);
    chk("post_rst_cleared_writes", w, DIRTY ? 0 : 16);
    chk("post_rst_e3", cap[3], DIRTY ? SENT : 32'h0);
    chk("post_rst_done_cyc", c, 17);

    // Commit in the same cycle as a vblank edge from IDLE waits for the next edge.
    vblank = 1'b0;
    @(negedge clk);
    vblank = 1'b1; commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    chk("same_edge_busy", busy, 1);
    chk("same_edge_cs0", bus.ppu_chipselect, 0);
    @(negedge clk);
    chk("same_edge_cs1", bus.ppu_chipselect, 0);
    burst(0, 0, w, c, rl, bd);
    chk("same_edge_done_cyc", c, 17);

`ifdef PPU_ATTR_UPLOADER_DIRTY_EN
    // Only entries written since the last upload go to the PPU.
    bus.host_valid = 1'b1; bus.host_index = 4'd1; bus.host_data = 32'h1111_0001;
    @(negedge clk);
    bus.host_index = 4'd9; bus.host_data = 32'h9999_0009;
    @(negedge clk);
    bus.host_valid = 1'b0;
    pulse_commit();
    burst(0, 0, w, c, rl, bd);
    chk("dirty_writes", w, 2);
    chk("dirty_e1", cap[1], 32'h1111_0001);
    chk("dirty_e9", cap[9], 32'h9999_0009);
    chk("dirty_done_cyc", c, 17);
    pulse_commit();
    burst(0, 0, w, c, rl, bd);
    chk("clean_writes", w, 0);
    chk("clean_done_cyc", c, 17);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_attr_uploader.md
# ppu_attr_uploader

Bus-initiator counterpart to the PPU register port: holds a CPU-side shadow copy of the sprite attribute table and, once the CPU commits a frame, replays it into the PPU as a burst of chipselect/write cycles at the next vertical-blank start. This gives tear-free sprite updates without the CPU timing its own writes. It sits between the host bridge and the PPU slave port (PPU address bits [9:8] = 2'b00 selects the attribute table).

## Interface
Parameters:
- NUM_ATTR, 16, shadow entries copied per frame; power of two, 2..16 (PPU attribute table depth).
- TABLE_SEL, 2'b00, value driven on ppu_address[9:8] (attribute table region).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- host_valid  in  1  host write request to shadow entry.
- host_ready  out  1  shadow accepts host write this cycle.
- host_index  in  4  shadow entry index; bits above log2(NUM_ATTR) ignored.
- host_data  in  32  attribute word ({color[31:28], sprite base[27:20], x[19:10], y[9:0]}).
- commit  in  1  one-cycle pulse: shadow is frame-complete, upload at next vblank.
- vblank  in  1  level, high outside active video (inverse of vertical part of VGA_BLANK_n).
- ppu_chipselect  out  1  to PPU slave.
- ppu_write  out  1  to PPU slave.
- ppu_address  out  16  {6'b0, TABLE_SEL, 4'b0, index}.
- ppu_writedata  out  32  shadow[index].
- busy  out  1  high while pending or copying.
- done  out  1  one-cycle pulse after last copy cycle.

## Operation
- States: IDLE, PENDING, COPY.
- IDLE: host_ready=1; host_valid writes host_data into shadow[host_index]. commit -> PENDING.
- PENDING: host_ready=1 (later writes still land in this upload). Registered vblank_q; edge = vblank & !vblank_q. On edge -> COPY, idx=0.
- COPY: host_ready=0; host must hold valid/data. One cycle per entry, idx 0..NUM_ATTR-1; ppu_chipselect=ppu_write=1, ppu_address/ppu_writedata from idx. After idx=NUM_ATTR-1 -> IDLE, done=1 next cycle.
- commit during COPY: latched; next state PENDING instead of IDLE; done still pulses.
- commit in PENDING: no effect (single pending upload).
- commit in the same cycle as an edge while IDLE: goes to PENDING; upload waits for the following edge.
- vblank deasserting during COPY: copy completes regardless.
- busy = (state != IDLE).
- Reset (any time, incl. mid-COPY): state IDLE, idx 0, vblank_q 0, pending commit cleared, shadow cleared to 0; outputs: host_ready 1 after reset released (0 during reset), ppu_chipselect 0, ppu_write 0, ppu_address 0, ppu_writedata 0, busy 0, done 0.

## Timing
- Host write: accepted on rising clk edge with host_valid & host_ready; readable by copy the next cycle.
- Edge detect registered: first PPU write asserted exactly 1 cycle after the cycle vblank first samples high.
- COPY lasts exactly NUM_ATTR cycles, back-to-back, all outputs registered.
- done asserted the cycle after the final copy cycle; busy drops in that same cycle unless a commit was latched.
- PPU accepts one write per cycle; no back-pressure from PPU.

## Configuration
- PPU_ATTR_UPLOADER_DIRTY_EN defined: per-entry dirty bit, set by accepted host write, cleared when that entry is copied. COPY still scans all NUM_ATTR cycles but asserts ppu_chipselect/ppu_write only for dirty entries; address/data still driven. All-clean upload: NUM_ATTR cycles, no writes, done pulses. Reset clears dirty bits.
- Undefined: every entry written every upload; no dirty state.

## Test plan
- Reset, write shadow[3]=32'hA0F0_2864, commit, raise vblank -> 16 consecutive writes starting 1 cycle after rise, address 16'h0003 carries 32'hA0F0_2864, others 0; done pulse; busy low after.
- host_valid held during COPY -> host_ready=0 for 16 cycles, write lands after; not in current upload, present in next.
- commit mid-COPY -> busy stays high, second 16-write burst at next vblank rise, two done pulses total.
- No commit, vblank toggles -> no ppu_write ever asserted.
- Assert reset at copy idx=7 -> ppu_write/chipselect low immediately, busy 0; next vblank produces no burst.
- DIRTY_EN: write entries 1 and 9, commit, vblank -> exactly 2 writes (addresses 16'h0001, 16'h0009); repeat commit without host writes -> 0 writes, done pulses.
